// File: rtl/mem_arbiter.sv
// Arbitrates N_MASTERS request channels onto one memory port and issues a single
// command at a time. Read data is returned RD_LATENCY clocks after the address.
module mem_arbiter #(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int RR_MODE    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          req,
    input  logic [N_MASTERS-1:0]          we,
    input  logic [N_MASTERS*ADDR_W-1:0]   addr,
    input  logic [N_MASTERS*DATA_W-1:0]   wdata,
    output logic [N_MASTERS-1:0]          gnt,
    output logic [N_MASTERS-1:0]          rvalid,
    output logic [DATA_W-1:0]             rdata,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_we,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          busy
);
    localparam int IDX_W = $clog2(N_MASTERS);
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  winner_c;
    logic [IDX_W-1:0]  ptr_next;
    logic [CNT_W-1:0]  cnt;
    logic              found;
    int                scan_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    // NOTE: every signal written here gets a default before the loop; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        found    = 1'b0;
        winner_c = '0;
        scan_idx = 0;
        for (int k = 0; k < N_MASTERS; k++) begin
            scan_idx = (RR_MODE != 0) ? (int'(ptr) + k) % N_MASTERS : k;
            if (!found && req[scan_idx]) begin
                found    = 1'b1;
                winner_c = IDX_W'(scan_idx);
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (winner_c == IDX_W'(k)) begin
                sel_addr  = addr[k*ADDR_W +: ADDR_W];
                sel_wdata = wdata[k*DATA_W +: DATA_W];
                sel_we    = we[k];
            end
        end
    end

    assign ptr_next = (winner == IDX_W'(N_MASTERS - 1)) ? '0 : winner + IDX_W'(1);
    assign busy     = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge value of every other register regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            winner    <= '0;
            cnt       <= '0;
            gnt       <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            // Pulse outputs fall back to zero unless a state below raises them.
            gnt    <= '0;
            rvalid <= '0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        winner    <= winner_c;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_we    <= sel_we;
                        gnt       <= N_MASTERS'(1) << winner_c;
                        state     <= CMD;
                    end
                end
                CMD: begin
                    if (RR_MODE != 0) ptr <= ptr_next;
                    // mem_we still carries the latched command type during CMD.
                    if (mem_we) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= CNT_W'(RD_LATENCY - 1);
                        state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    if (cnt == '0) begin
                        rdata  <= mem_rdata;
                        rvalid <= N_MASTERS'(1) << winner;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin 3-channel instance with 2-cycle memory and a
// fixed-priority 3-channel instance with 1-cycle memory, checked against a schedule model.
module tb_mem_arbiter;
    localparam int N    = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int RCYC = 800;
    localparam int ESZ  = RCYC + LAT + 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // round-robin instance
    logic [N-1:0]    req, we, gnt, rvalid;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;
    logic            mem_we, busy;

    // fixed-priority instance
    logic [N-1:0]    f_req, f_we, f_gnt, f_rvalid;
    logic [N*AW-1:0] f_addr;
    logic [N*DW-1:0] f_wdata;
    logic [DW-1:0]   f_rdata, f_mem_wdata, f_mem_rdata;
    logic [AW-1:0]   f_mem_addr;
    logic            f_mem_we, f_busy;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .RR_MODE(1)) dut_rr (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .RR_MODE(0)) dut_fp (
        .clk(clk), .reset(reset), .req(f_req), .we(f_we), .addr(f_addr), .wdata(f_wdata),
        .gnt(f_gnt), .rvalid(f_rvalid), .rdata(f_rdata), .mem_addr(f_mem_addr), .mem_we(f_mem_we),
        .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata), .busy(f_busy)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'h5A00_0000 ^ 32'(i * 32'h0101_0103);
    endfunction

    // 256-word memory with a LAT-stage registered read path; refilled while in reset.
    logic [DW-1:0] mem  [0:255];
    logic [DW-1:0] pipe [0:LAT-1];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        pipe[0] <= mem[mem_addr[7:0]];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata   = pipe[LAT-1];
    assign f_mem_rdata = ~f_mem_addr;

    // expected schedule for the random test, indexed by cycle
    logic [N-1:0]  e_gnt   [0:ESZ-1];
    logic [N-1:0]  e_rv    [0:ESZ-1];
    logic          e_we    [0:ESZ-1];
    logic          e_busy  [0:ESZ-1];
    logic [AW-1:0] e_addr  [0:ESZ-1];
    logic [DW-1:0] e_wdata [0:ESZ-1];
    logic [DW-1:0] e_rd    [0:ESZ-1];
    logic [DW-1:0] ref_mem [0:255];

    function automatic int onehot_idx(input logic [N-1:0] v);
        if (!$onehot(v)) return -1;
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic clear_inputs();
        req = '0; we = '0; addr = '0; wdata = '0;
        f_req = '0; f_we = '0; f_addr = '0; f_wdata = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({gnt, rvalid, rdata, mem_addr, mem_we, mem_wdata, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_rr: outputs=%h expected all zero",
                     {gnt, rvalid, rdata, mem_addr, mem_we, mem_wdata, busy});
        end
        n_cmp++;
        if ({f_gnt, f_rvalid, f_rdata, f_mem_addr, f_mem_we, f_mem_wdata, f_busy} !== '0) begin
            n_err++;
            $display("FAIL reset_fp: outputs=%h expected all zero",
                     {f_gnt, f_rvalid, f_rdata, f_mem_addr, f_mem_we, f_mem_wdata, f_busy});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({gnt, rvalid, mem_we, busy} !== '0) begin
                n_err++;
                $display("FAIL idle cycle %0d: gnt=%b rvalid=%b mem_we=%b busy=%b expected all 0",
                         i, gnt, rvalid, mem_we, busy);
            end
        end
    endtask

    task automatic test_single_write();
        clear_inputs();
        req = 3'b010; we = 3'b010;
        addr[AW +: AW] = 32'h10; wdata[DW +: DW] = 32'hDEAD_BEEF;
        @(negedge clk);
        n_cmp++;
        if ({gnt, mem_we, mem_addr, mem_wdata, busy} !== {3'b010, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1}) begin
            n_err++;
            $display("FAIL write_cmd: gnt=%b we=%b addr=%h wdata=%h busy=%b expected 010 1 10 deadbeef 1",
                     gnt, mem_we, mem_addr, mem_wdata, busy);
        end
        req = '0;
        @(negedge clk);
        n_cmp++;
        if ({gnt, mem_we, mem_addr, busy} !== {3'b000, 1'b0, 32'h10, 1'b0}) begin
            n_err++;
            $display("FAIL write_after: gnt=%b we=%b addr=%h busy=%b expected 000 0 10 0",
                     gnt, mem_we, mem_addr, busy);
        end
    endtask

    task automatic test_single_read();
        clear_inputs();
        req = 3'b001; we = 3'b001;
        addr[0 +: AW] = 32'h20; wdata[0 +: DW] = 32'h1234_5678;
        @(negedge clk);
        n_cmp++;
        if (gnt !== 3'b001) begin
            n_err++;
            $display("FAIL read_preload_gnt: gnt=%b expected 001", gnt);
        end
        req = '0;
        @(negedge clk);
        req = 3'b001; we = 3'b000;
        @(negedge clk);
        n_cmp++;
        if ({gnt, mem_we, mem_addr} !== {3'b001, 1'b0, 32'h20}) begin
            n_err++;
            $display("FAIL read_gnt: gnt=%b we=%b addr=%h expected 001 0 20", gnt, mem_we, mem_addr);
        end
        req = '0;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            n_cmp++;
            if (k <= LAT) begin
                if ({rvalid, busy} !== {3'b000, 1'b1}) begin
                    n_err++;
                    $display("FAIL read_wait t+%0d: rvalid=%b busy=%b expected 000 1", k, rvalid, busy);
                end
            end else if ({rvalid, rdata, busy} !== {3'b001, 32'h1234_5678, 1'b0}) begin
                n_err++;
                $display("FAIL read_data t+%0d: rvalid=%b rdata=%h busy=%b expected 001 12345678 0",
                         k, rvalid, rdata, busy);
            end
        end
    endtask

    task automatic test_rr_contention();
        int exp_order[4] = '{0, 1, 2, 0};
        int got[$];
        int budget = 0;
        apply_reset();
        req = 3'b111; we = 3'b101;
        for (int ch = 0; ch < N; ch++) addr[ch*AW +: AW] = AW'(32'h100 + ch * 4);
        while (got.size() < 4 && budget < 60) begin
            @(negedge clk);
            budget++;
            if (gnt !== '0) begin
                got.push_back(onehot_idx(gnt));
                if (got.size() == 4) req = '0;
            end
        end
        n_cmp++;
        if (got.size() != 4) begin
            n_err++;
            $display("FAIL rr_timeout: grants seen=%0d expected 4", got.size());
        end
        foreach (got[i]) begin
            n_cmp++;
            if (got[i] != exp_order[i]) begin
                n_err++;
                $display("FAIL rr_order[%0d]: granted ch%0d expected ch%0d", i, got[i], exp_order[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_fixed_priority();
        int seen = 0;
        int budget = 0;
        bit got_ch2 = 1'b0;
        apply_reset();
        f_req = 3'b101; f_we = 3'b101;
        f_addr[0 +: AW] = 32'h50; f_addr[2*AW +: AW] = 32'h58;
        while (seen < 4 && budget < 40) begin
            @(negedge clk);
            budget++;
            if (f_gnt !== '0) begin
                seen++;
                n_cmp++;
                if ({f_gnt, f_mem_we, f_mem_addr} !== {3'b001, 1'b1, 32'h50}) begin
                    n_err++;
                    $display("FAIL fp_grant%0d: gnt=%b we=%b addr=%h expected 001 1 50",
                             seen, f_gnt, f_mem_we, f_mem_addr);
                end
            end
        end
        n_cmp++;
        if (seen != 4) begin
            n_err++;
            $display("FAIL fp_timeout: grants seen=%0d expected 4", seen);
        end
        f_req = 3'b100;
        budget = 0;
        while (!got_ch2 && budget < 10) begin
            @(negedge clk);
            budget++;
            if (f_gnt !== '0) begin
                got_ch2 = 1'b1;
                f_req = '0;
                n_cmp++;
                if (f_gnt !== 3'b100) begin
                    n_err++;
                    $display("FAIL fp_ch2: gnt=%b expected 100", f_gnt);
                end
            end
        end
        n_cmp++;
        if (!got_ch2) begin
            n_err++;
            $display("FAIL fp_ch2_timeout: no grant within 10 cycles expected ch2 grant");
        end
        f_req = '0;
        @(negedge clk);
        f_req = 3'b010; f_we = 3'b000; f_addr[AW +: AW] = 32'hABC;
        @(negedge clk);
        n_cmp++;
        if (f_gnt !== 3'b010) begin
            n_err++;
            $display("FAIL fp_read_gnt: gnt=%b expected 010", f_gnt);
        end
        f_req = '0;
        @(negedge clk);
        n_cmp++;
        if ({f_rvalid, f_busy} !== {3'b000, 1'b1}) begin
            n_err++;
            $display("FAIL fp_read_wait: rvalid=%b busy=%b expected 000 1", f_rvalid, f_busy);
        end
        @(negedge clk);
        n_cmp++;
        if ({f_rvalid, f_rdata, f_busy} !== {3'b010, ~32'hABC, 1'b0}) begin
            n_err++;
            $display("FAIL fp_read_data: rvalid=%b rdata=%h busy=%b expected 010 %h 0",
                     f_rvalid, f_rdata, f_busy, ~32'hABC);
        end
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        req = 3'b010; we = 3'b000; addr[AW +: AW] = 32'h30;
        @(negedge clk);
        n_cmp++;
        if (gnt !== 3'b010) begin
            n_err++;
            $display("FAIL abort_gnt: gnt=%b expected 010", gnt);
        end
        req = '0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_busy: busy=%b expected 1", busy);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({gnt, rvalid, rdata, mem_addr, mem_we, mem_wdata, busy} !== '0) begin
            n_err++;
            $display("FAIL abort_async: outputs=%h expected all zero",
                     {gnt, rvalid, rdata, mem_addr, mem_we, mem_wdata, busy});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({gnt, rvalid, busy} !== '0) begin
                n_err++;
                $display("FAIL abort_quiet cycle %0d: gnt=%b rvalid=%b busy=%b expected all 0",
                         i, gnt, rvalid, busy);
            end
        end
        req = 3'b110; we = 3'b110;
        addr[AW +: AW] = 32'h44; addr[2*AW +: AW] = 32'h48; wdata[DW +: DW] = 32'hCAFE_0001;
        @(negedge clk);
        n_cmp++;
        if ({gnt, mem_we, mem_addr} !== {3'b010, 1'b1, 32'h44}) begin
            n_err++;
            $display("FAIL abort_rearb: gnt=%b we=%b addr=%h expected 010 1 44", gnt, mem_we, mem_addr);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int ptr = 0;
        int next_free = 0;
        int w, a, g, rv_c;
        logic [AW-1:0] cur_addr = '0;
        logic [DW-1:0] cur_wdata = '0;
        logic [DW-1:0] cur_rdata = '0;
        for (int i = 0; i < ESZ; i++) begin
            e_gnt[i] = '0; e_rv[i] = '0; e_we[i] = 1'b0; e_busy[i] = 1'b0;
            e_addr[i] = '0; e_wdata[i] = '0; e_rd[i] = '0;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        apply_reset();
        for (int c = 0; c < RCYC; c++) begin
            n_cmp++;
            if ({gnt, rvalid, mem_we, busy} !== {e_gnt[c], e_rv[c], e_we[c], e_busy[c]}) begin
                n_err++;
                $display("FAIL rand_ctrl cycle %0d: gnt=%b rvalid=%b we=%b busy=%b expected %b %b %b %b",
                         c, gnt, rvalid, mem_we, busy, e_gnt[c], e_rv[c], e_we[c], e_busy[c]);
            end
            if (e_gnt[c] != '0) begin
                cur_addr  = e_addr[c];
                cur_wdata = e_wdata[c];
            end
            if (e_rv[c] != '0) cur_rdata = e_rd[c];
            n_cmp++;
            if ({mem_addr, mem_wdata, rdata} !== {cur_addr, cur_wdata, cur_rdata}) begin
                n_err++;
                $display("FAIL rand_data cycle %0d: addr=%h wdata=%h rdata=%h expected %h %h %h",
                         c, mem_addr, mem_wdata, rdata, cur_addr, cur_wdata, cur_rdata);
            end
            // Requesters: a granted channel drops req; an idle one may raise a new command.
            for (int ch = 0; ch < N; ch++) begin
                if (e_gnt[c][ch]) begin
                    req[ch] = 1'b0;
                end else if (!req[ch] && $urandom_range(0, 3) == 0) begin
                    req[ch] = 1'b1;
                    we[ch]  = 1'($urandom_range(0, 1));
                    addr[ch*AW +: AW]  = AW'($urandom_range(0, 255));
                    wdata[ch*DW +: DW] = DW'($urandom);
                end
            end
            if (c >= next_free && req != '0) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && req[(ptr + k) % N]) w = (ptr + k) % N;
                a = int'(addr[w*AW +: 8]);
                g = c + 1;
                e_gnt[g]   = N'(1) << w;
                e_we[g]    = we[w];
                e_addr[g]  = addr[w*AW +: AW];
                e_wdata[g] = wdata[w*DW +: DW];
                if (we[w]) begin
                    ref_mem[a] = wdata[w*DW +: DW];
                    next_free  = c + 2;
                end else begin
                    rv_c       = c + LAT + 2;
                    e_rv[rv_c] = N'(1) << w;
                    e_rd[rv_c] = ref_mem[a];
                    next_free  = rv_c;
                end
                for (int b = c + 1; b < next_free; b++) e_busy[b] = 1'b1;
                ptr = (w + 1) % N;
            end
            @(negedge clk);
        end
        req = '0;
        repeat (LAT + 3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_idle();
        test_single_write();
        test_single_read();
        test_rr_contention();
        test_fixed_priority();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t expected completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 2: number of requesting channels (range 2..8).
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width.
REQ-004 Parameter RD_LATENCY, default 1: memory clocks from registered read address to valid mem_rdata (range 1..4).
REQ-005 Parameter RR_MODE, default 1: 1 = round-robin arbitration, 0 = fixed priority (channel 0 highest).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 req  input  N_MASTERS  per-channel access request, level.
REQ-009 we  input  N_MASTERS  per-channel write enable (1 = write, 0 = read).
REQ-010 addr  input  N_MASTERS*ADDR_W  per-channel address; channel i at bits [i*ADDR_W +: ADDR_W].
REQ-011 wdata  input  N_MASTERS*DATA_W  per-channel write data, packed the same way.
REQ-012 gnt  output  N_MASTERS  one-cycle pulse: channel's command issued to memory.
REQ-013 rvalid  output  N_MASTERS  one-cycle pulse: rdata holds the channel's read result.
REQ-014 rdata  output  DATA_W  shared read data, valid only while some rvalid bit is high.
REQ-015 mem_addr  output  ADDR_W  registered memory address.
REQ-016 mem_we  output  1  registered memory write strobe.
REQ-017 mem_wdata  output  DATA_W  registered memory write data.
REQ-018 mem_rdata  input  DATA_W  memory read data.
REQ-019 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-020 FSM states SHALL be IDLE, CMD, RDWAIT; one transaction outstanding at most.
REQ-021 IDLE with req==0: stay IDLE; mem_we=0; gnt, rvalid=0.
REQ-022 IDLE with any req bit set: select winner per arbitration, latch winner index, addr, we, wdata into mem_addr/mem_we/mem_wdata; next state CMD.
REQ-023 CMD: gnt[winner]=1 for exactly this cycle; mem_we reflects latched we for this cycle only; write -> IDLE next; read -> RDWAIT next with latency counter loaded to RD_LATENCY-1.
REQ-024 RDWAIT: counter decrements each cycle; when counter==0 capture mem_rdata into rdata and pulse rvalid[winner] next cycle, return to IDLE in that same cycle.
REQ-025 Read latency: rvalid asserted exactly RD_LATENCY+1 cycles after gnt; write occupies 2 cycles (IDLE->CMD), read occupies RD_LATENCY+2 cycles.
REQ-026 req/we/addr/wdata SHALL be sampled only in IDLE; changes outside IDLE are ignored; a requester keeps req high until its gnt.
REQ-027 Round-robin: pointer starts at 0; winner is first set req bit at or after pointer, scanning upward with wrap N_MASTERS-1 -> 0; on CMD, pointer <- winner+1 modulo N_MASTERS.
REQ-028 Fixed priority: winner is lowest-index set req bit; pointer unused.
REQ-029 mem_we SHALL be 0 in IDLE and RDWAIT; mem_addr and mem_wdata hold last latched value outside CMD.
REQ-030 rdata holds its last captured value between rvalid pulses.
REQ-031 At most one gnt bit and at most one rvalid bit high in any cycle; gnt and rvalid never high in the same cycle.

Reset
REQ-032 reset low SHALL asynchronously force IDLE, pointer=0, counter=0, gnt=0, rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, busy=0.
REQ-033 Reset during CMD or RDWAIT aborts the transaction: no gnt or rvalid after release; first post-reset arbitration starts from channel 0.

Verification
REQ-034 Single write: ch1 req, we=1, addr=0x10, wdata=0xDEADBEEF -> next cycle mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, gnt=2'b10; mem_we=0 the cycle after.
REQ-035 Single read, RD_LATENCY=2: ch0 reads 0x20, memory returns 0x12345678 -> gnt[0] at cycle t, rvalid[0]=1 and rdata=0x12345678 at t+3.
REQ-036 Round-robin contention, N_MASTERS=3, all req held: grant order 0,1,2,0 with pointer wrap.
REQ-037 Fixed priority (RR_MODE=0), ch0 and ch2 held: ch0 granted every transaction, ch2 never until ch0 drops req.
REQ-038 Reset asserted mid-RDWAIT -> all outputs zero immediately, no rvalid after release; next req from ch1 granted normally.
REQ-039 Idle with req=0 for 10 cycles -> busy=0, mem_we=0, no gnt/rvalid pulses.
